pipelined_adder_tree: RTL and testbench
=======================================

// Module: pipelined_adder_tree
// PURPOSE
//  Registered, parameterised reduction tree. Each accepted beat carries NUM lanes of IN_WIDTH.
//  All lanes are summed, and per-beat sums are accumulated over a group of beats closed by in_last.
//  Emits one OUT_WIDTH result per group, with a valid/ready handshake.
//  Sits between the NN PE array (partial products) and the activation/requant stage.
// PARAMETERS
//  IN_WIDTH   8   width of one input lane
//  NUM        16  lanes per beat; any value >= 1 (non-power-of-2 is zero-padded)
//  OUT_WIDTH  32  result/accumulator width; must be >= IN_WIDTH
//  SIGNED     1   1: lanes two's-complement, sign-extended; 0: unsigned, zero-extended
//  SATURATE   1   1: accumulator clamps at OUT_WIDTH min/max; 0: wraps modulo 2^OUT_WIDTH
// PORTS
//  clk        in   1                 clock, rising edge
//  rst        in   1                 synchronous reset, active-high
//  in_valid   in   1                 input beat valid
//  in_ready   out  1                 block can accept a beat
//  in_last    in   1                 beat closes the current accumulation group
//  in_data    in   NUM*IN_WIDTH      lanes; lane i = in_data[i*IN_WIDTH +: IN_WIDTH]
//  out_valid  out  1                 result valid
//  out_ready  in   1                 downstream accepts result
//  out_data   out  OUT_WIDTH         group sum
//  out_sat    out  1                 1 if the accumulator clamped at any point in this group
// BEHAVIOUR
//  - Constants: LEVELS = clog2(NUM) (0 when NUM=1). Pipeline depth D = LEVELS + 1 (tree regs + accumulator).
//  - Reset (rst=1 at posedge): all stage valids, accumulator, out_data, out_valid and out_sat go to 0.
//    in_ready reads 1 from the first cycle after reset; this holds even mid-group (a partial group is discarded).
//  - Handshake: a beat is accepted when in_valid & in_ready; a result is taken when out_valid & out_ready.
//    adv = ~out_valid | out_ready. in_ready = adv (combinational).
//    When adv=0 every stage holds, including bubbles. Data and valid advance together; no combinational
//    path from in_valid to out_valid.
//  - Tree: level k adds pairs from level k-1. Level-k width = IN_WIDTH + k, extended per SIGNED, so a
//    level never overflows. Odd element count: the last operand passes through extended.
//    Lanes >= NUM read as 0. Each level is registered together with a valid and the last flag.
//  - Accumulator stage: tree sum is extended to OUT_WIDTH. On a valid tree beat, acc <= (first ? 0 : acc) + sum.
//    first is set after reset and after every last beat.
//    SATURATE=1: the result clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] when SIGNED, or [0, 2^OUT_WIDTH-1]
//    when unsigned, and sets the group's sticky sat flag. SATURATE=0: wraps; out_sat is always 0.
//  - Output: on the last beat, out_data <= final acc, out_sat <= sticky flag, out_valid <= 1.
//    The sticky flag clears for the next group. A non-last beat never raises out_valid.
//  - Latency: out_valid rises exactly D cycles after the accepting edge of a last beat, if unstalled.
//    Throughput is 1 beat/cycle. A group of one beat (in_last=1) is legal.
//  - Simultaneous: an output taken and a new last result arriving in the same cycle -> out_data is
//    replaced, out_valid stays 1, no bubble.
//  - in_last=0 beats with no follow-up stay pending in the accumulator indefinitely; nothing is emitted.
//  - X on in_data with in_valid=0 must not propagate to out_data.
// STRUCTURE
//  - Package nn_arith_pkg: function clog2_min1(n); typedef enum {ARITH_UNSIGNED, ARITH_SIGNED};
//    functions sat_max/sat_min(width, signed).
//  - Sub-module adder_tree_level #(IN_W, N_IN, SIGNED): one registered pairwise level with valid/last and
//    hold enable. The top generates LEVELS instances plus the accumulator/output stage.
//  - No memories; all state in flops. Target 150-300 lines total.
// TESTING
//  1 NUM=16,IN=8,S=1: single beat of all lanes = 1, last=1 -> out_data=16 exactly 5 cycles later, out_sat=0.
//  2 Group of 3 beats (lanes all -128, all 127, all 2), last on 3rd -> one result: 16*(-128+127+2)=16;
//    no out_valid before then.
//  3 OUT_WIDTH=12,SAT=1: 2 beats of all lanes 127 -> 4064 clamps to 2047, out_sat=1;
//    next group 1 beat all 0 -> 0, out_sat=0.
//  4 Back-pressure: 8 single-beat groups back-to-back, out_ready=0 for cycles 3-7 -> in_ready=0 while
//    stalled, all 8 results in order, none lost or duplicated.
//  5 rst asserted after 2 of 4 beats of a group -> out_valid=0 next cycle; a fresh 1-beat group of all 3
//    -> 48 (no stale partial sum).
//  6 NUM=5,SIGNED=0,SAT=0,OUT_WIDTH=8: lanes 255 x5 -> 1275 mod 256 = 251, latency LEVELS+1 = 4.

Source files
------------

// File: rtl/nn_arith_pkg.sv
// Arithmetic helpers shared by the NN reduction datapath: level counts, lane counts, clamp limits.
package nn_arith_pkg;

  typedef enum logic {ARITH_UNSIGNED = 1'b0, ARITH_SIGNED = 1'b1} arith_e;

  // ceil(log2(n)); n of 1 (or less) gives 0 tree levels
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // element count at tree level k for n input lanes
  function automatic int lanes_at(input int n, input int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

  // clamp limits as 64-bit two's complement; callers truncate to their own width (< 64)
  function automatic logic [63:0] sat_max(input int width, input arith_e mode);
    logic [63:0] ones;
    ones = '1;
    return (mode == ARITH_SIGNED) ? (ones >> (65 - width)) : (ones >> (64 - width));
  endfunction

  function automatic logic [63:0] sat_min(input int width, input arith_e mode);
    return (mode == ARITH_SIGNED) ? ~sat_max(width, ARITH_SIGNED) : '0;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered pairwise-add level of the reduction tree, 1 cycle latency.
// All state holds while en is low; an odd trailing lane passes through extended.
module adder_tree_level #(
  parameter int IN_W   = 8,
  parameter int N_IN   = 16,
  parameter int SIGNED = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  input  logic [N_IN*IN_W-1:0]                 in_data,
  output logic                                 out_valid,
  output logic                                 out_last,
  output logic [((N_IN+1)/2)*(IN_W+1)-1:0]     out_data
);

  localparam int N_OUT = (N_IN + 1) / 2;
  localparam int OW    = IN_W + 1;
  localparam int PW    = 2 * N_OUT * IN_W;

  logic [PW-1:0]       padded;
  logic [N_OUT*OW-1:0] sum;

  function automatic logic [OW-1:0] ext(input logic [IN_W-1:0] x);
    return {(SIGNED != 0) && x[IN_W-1], x};
  endfunction

  // zero lane fills the missing partner of an odd count
  assign padded = PW'(in_data);

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_OUT; i++)
      sum[i*OW +: OW] = ext(padded[2*i*IN_W +: IN_W]) + ext(padded[(2*i+1)*IN_W +: IN_W]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      out_last  <= in_last;
    end
  end

  // data only captured on real beats so idle-bus garbage never enters the tree
  always_ff @(posedge clk) begin
    if (en && in_valid) out_data <= sum;
  end

endmodule

// File: rtl/pipelined_adder_tree.sv
// NUM-lane adder tree plus group accumulator; result LEVELS+1 cycles after the last beat.
// Every stage, bubbles included, holds while a result waits: in_ready = ~out_valid | out_ready.
module pipelined_adder_tree
  import nn_arith_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int NUM       = 16,
  parameter int OUT_WIDTH = 32,
  parameter int SIGNED    = 1,
  parameter int SATURATE  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [NUM*IN_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_sat
);

  localparam int     LEVELS = clog2_min1(NUM);
  localparam int     SW     = IN_WIDTH + LEVELS;
  localparam int     AW     = ((SW > OUT_WIDTH) ? SW : OUT_WIDTH) + 1;
  localparam arith_e MODE   = (SIGNED != 0) ? ARITH_SIGNED : ARITH_UNSIGNED;
  localparam logic [AW-1:0] MAXV = AW'(sat_max(OUT_WIDTH, MODE));
  localparam logic [AW-1:0] MINV = AW'(sat_min(OUT_WIDTH, MODE));

  logic          adv, accept;
  logic [SW-1:0] tree_sum;
  logic          tree_valid, tree_last;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NI = lanes_at(NUM, k);
    localparam int NO = lanes_at(NUM, k + 1);
    localparam int W  = IN_WIDTH + k;
    logic [NI*W-1:0]     d_in;
    logic                v_in, l_in;
    logic [NO*(W+1)-1:0] q;
    logic                v, l;
    if (k == 0) begin : g_src
      assign d_in = in_data;
      assign v_in = accept;
      assign l_in = in_last;
    end else begin : g_src
      assign d_in = g_lvl[k-1].q;
      assign v_in = g_lvl[k-1].v;
      assign l_in = g_lvl[k-1].l;
    end
    adder_tree_level #(.IN_W(W), .N_IN(NI), .SIGNED(SIGNED)) u_level (
      .clk(clk), .rst(rst), .en(adv),
      .in_valid(v_in), .in_last(l_in), .in_data(d_in),
      .out_valid(v), .out_last(l), .out_data(q)
    );
  end

  if (LEVELS == 0) begin : g_flat
    assign tree_sum   = in_data;
    assign tree_valid = accept;
    assign tree_last  = in_last;
  end else begin : g_tree
    assign tree_sum   = g_lvl[LEVELS-1].q;
    assign tree_valid = g_lvl[LEVELS-1].v;
    assign tree_last  = g_lvl[LEVELS-1].l;
  end

  logic [OUT_WIDTH-1:0] acc, acc_nxt;
  logic                 first, sticky, ovf;
  logic                 acc_sb, sum_sb;
  logic [AW-1:0]        acc_x, sum_x, wide;

  assign acc_sb = (MODE == ARITH_SIGNED) && acc[OUT_WIDTH-1];
  assign sum_sb = (MODE == ARITH_SIGNED) && tree_sum[SW-1];

  // sum at a width that cannot overflow, then wrap or clamp into OUT_WIDTH
  always_comb begin
    acc_x = first ? '0 : {{(AW-OUT_WIDTH){acc_sb}}, acc};
    sum_x = {{(AW-SW){sum_sb}}, tree_sum};
    wide  = acc_x + sum_x;
    acc_nxt = wide[OUT_WIDTH-1:0];
    ovf = 1'b0;
    if (SATURATE != 0) begin
      if (MODE == ARITH_SIGNED) begin
        if ($signed(wide) > $signed(MAXV)) begin
          acc_nxt = MAXV[OUT_WIDTH-1:0];
          ovf = 1'b1;
        end else if ($signed(wide) < $signed(MINV)) begin
          acc_nxt = MINV[OUT_WIDTH-1:0];
          ovf = 1'b1;
        end
      end else if (wide > MAXV) begin
        acc_nxt = MAXV[OUT_WIDTH-1:0];
        ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      first     <= 1'b1;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= tree_valid & tree_last;
      if (tree_valid) begin
        acc    <= acc_nxt;
        first  <= tree_last;
        sticky <= tree_last ? 1'b0 : (sticky | ovf);
        if (tree_last) begin
          out_data <= acc_nxt;
          out_sat  <= sticky | ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench: three parameterisations of pipelined_adder_tree on one clock and reset,
// expected values computed by hand in the step comments.
module tb_pipelined_adder_tree;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // A: 16 x 8-bit signed, 32-bit saturating accumulator
  logic         a_valid, a_ready, a_last, a_ovalid, a_oready, a_osat;
  logic [127:0] a_data;
  logic [31:0]  a_odata;
  // B: same tree, 12-bit saturating accumulator
  logic         b_valid, b_ready, b_last, b_ovalid, b_oready, b_osat;
  logic [127:0] b_data;
  logic [11:0]  b_odata;
  // C: 5 x 8-bit unsigned, 8-bit wrapping accumulator
  logic         c_valid, c_ready, c_last, c_ovalid, c_oready, c_osat;
  logic [39:0]  c_data;
  logic [7:0]   c_odata;

  pipelined_adder_tree #(.IN_WIDTH(8), .NUM(16), .OUT_WIDTH(32), .SIGNED(1), .SATURATE(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_last(a_last),
    .in_data(a_data), .out_valid(a_ovalid), .out_ready(a_oready), .out_data(a_odata), .out_sat(a_osat)
  );

  pipelined_adder_tree #(.IN_WIDTH(8), .NUM(16), .OUT_WIDTH(12), .SIGNED(1), .SATURATE(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_last(b_last),
    .in_data(b_data), .out_valid(b_ovalid), .out_ready(b_oready), .out_data(b_odata), .out_sat(b_osat)
  );

  pipelined_adder_tree #(.IN_WIDTH(8), .NUM(5), .OUT_WIDTH(8), .SIGNED(0), .SATURATE(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_last(c_last),
    .in_data(c_data), .out_valid(c_ovalid), .out_ready(c_oready), .out_data(c_odata), .out_sat(c_osat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic ovalid(input int which);
    case (which)
      0:       return a_ovalid;
      1:       return b_ovalid;
      default: return c_ovalid;
    endcase
  endfunction

  // called right after the accepting edge; n = edges until out_valid, accepting edge counted as 1
  task automatic wait_out(input int which, output int n);
    n = 1;
    while (!ovalid(which) && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, sent, recv;
    rst = 1'b1;
    a_valid = 0; a_last = 0; a_data = '0; a_oready = 1;
    b_valid = 0; b_last = 0; b_data = '0; b_oready = 1;
    c_valid = 0; c_last = 0; c_data = '0; c_oready = 1;
    step();
    step();
    rst = 1'b0;

    // reset state
    check("rst_out_valid", 64'(a_ovalid), 64'(0));
    check("rst_out_data", 64'(a_odata), 64'(0));
    check("rst_out_sat", 64'(a_osat), 64'(0));
    check("rst_in_ready", 64'(a_ready), 64'(1));

    // single beat, all lanes 1 -> 16 after 5 edges (4 tree levels + accumulator)
    a_valid = 1; a_last = 1; a_data = {16{8'd1}};
    step();
    a_valid = 0; a_last = 0;
    wait_out(0, n);
    check("t1_latency", 64'(n), 64'(5));
    check("t1_data", 64'(a_odata), 64'(16));
    check("t1_sat", 64'(a_osat), 64'(0));
    step();
    check("t1_taken", 64'(a_ovalid), 64'(0));

    // three-beat group: 16*(-128) + 16*127 + 16*2 = 16
    a_valid = 1; a_last = 0; a_data = {16{8'h80}};
    step();
    check("t2_no_early_1", 64'(a_ovalid), 64'(0));
    a_data = {16{8'h7f}};
    step();
    check("t2_no_early_2", 64'(a_ovalid), 64'(0));
    a_data = {16{8'h02}}; a_last = 1;
    step();
    a_valid = 0; a_last = 0;
    wait_out(0, n);
    check("t2_latency", 64'(n), 64'(5));
    check("t2_data", 64'(a_odata), 64'(16));
    check("t2_sat", 64'(a_osat), 64'(0));
    step();

    // 12-bit accumulator: 2032 + 2032 = 4064 clamps to 2047
    b_valid = 1; b_last = 0; b_data = {16{8'h7f}};
    step();
    b_last = 1;
    step();
    b_valid = 0; b_last = 0;
    wait_out(1, n);
    check("t3_latency", 64'(n), 64'(5));
    check("t3_clamp", 64'(b_odata), 64'(2047));
    check("t3_sat", 64'(b_osat), 64'(1));
    step();
    // following group starts clean: 0, no sat
    b_valid = 1; b_last = 1; b_data = '0;
    step();
    b_valid = 0; b_last = 0;
    wait_out(1, n);
    check("t3_latency2", 64'(n), 64'(5));
    check("t3_zero", 64'(b_odata), 64'(0));
    check("t3_sat_clear", 64'(b_osat), 64'(0));
    step();

    // eight single-beat groups (lanes g+1 -> 16*(g+1)), out_ready low in cycles 3..7;
    // the first result appears in cycle 5, so in_ready is 1 at cycle 3 and 0 in cycles 5..7
    sent = 0;
    recv = 0;
    for (int c = 0; c < 40; c++) begin
      a_oready = !(c >= 3 && c <= 7);
      a_valid  = (sent < 8);
      a_last   = 1;
      a_data   = {16{8'(sent + 1)}};
      #1;
      if (c == 3) check("t4_ready_pre_stall", 64'(a_ready), 64'(1));
      if (c >= 5 && c <= 7) check($sformatf("t4_ready_stall_c%0d", c), 64'(a_ready), 64'(0));
      if (a_ovalid && a_oready) begin
        check($sformatf("t4_result%0d", recv), 64'(a_odata), 64'(16 * (recv + 1)));
        recv++;
      end
      if (a_valid && a_ready) sent++;
      step();
    end
    a_valid = 0; a_last = 0; a_oready = 1;
    check("t4_sent", 64'(sent), 64'(8));
    check("t4_received", 64'(recv), 64'(8));

    // reset after 2 of 4 beats (lanes 5) discards the partial group
    a_valid = 1; a_last = 0; a_data = {16{8'd5}};
    step();
    step();
    a_valid = 0; a_data = 'x; rst = 1;
    step();
    rst = 0;
    check("t5_out_valid", 64'(a_ovalid), 64'(0));
    check("t5_out_data", 64'(a_odata), 64'(0));
    check("t5_in_ready", 64'(a_ready), 64'(1));
    step();
    step();
    // fresh group, lanes 3 -> 48, with X on the idle bus around it
    a_valid = 1; a_last = 1; a_data = {16{8'd3}};
    step();
    a_valid = 0; a_last = 0; a_data = 'x;
    wait_out(0, n);
    check("t5_latency", 64'(n), 64'(5));
    check("t5_data", 64'(a_odata), 64'(48));
    check("t5_sat", 64'(a_osat), 64'(0));
    a_data = '0;
    step();

    // NUM=5 unsigned wrapping: 5*255 = 1275 mod 256 = 251, 3 levels + accumulator = 4 edges
    c_valid = 1; c_last = 1; c_data = {5{8'hff}};
    step();
    c_valid = 0; c_last = 0;
    wait_out(2, n);
    check("t6_latency", 64'(n), 64'(4));
    check("t6_data", 64'(c_odata), 64'(251));
    check("t6_sat", 64'(c_osat), 64'(0));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
